adc_rx: RTL and testbench

ADC_RX -- requirements
Module: adc_rx

---
 rtl/adc_rx_if.sv | 31 +++
 rtl/adc_rx.sv | 103 ++++++++++
 tb/tb_adc_rx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_rx_if.sv
// Signal bundle between adc_rx and its environment: frame enable, serial ADC lines and the
// sign-extended sample pair with its valid strobe.
interface adc_rx_if;
    logic        en;
    logic        miso;
    logic        conv;
    logic        sck;
    logic        valid;
    logic [15:0] sample_l;
    logic [15:0] sample_r;

    modport master (
        output en,
        output miso,
        input  conv,
        input  sck,
        input  valid,
        input  sample_l,
        input  sample_r
    );

    modport slave (
        input  en,
        input  miso,
        output conv,
        output sck,
        output valid,
        output sample_l,
        output sample_r
    );
endinterface

// File: rtl/adc_rx.sv
// Two-channel serial ADC receiver: 1024-clk frames of 64 slots x 16 clk, conv in slot 0,
// sck in slots 1..34, two 14-bit words shifted in MSB first and presented at slot 35.
module adc_rx (
    input logic   clk,
    input logic   reset_n,
    adc_rx_if.slave bus
);

    typedef enum logic {StIdle, StFrame} state_e;

    state_e      state_q, state_d;
    logic [3:0]  sub_q, sub_d;
    logic [5:0]  slot_q, slot_d;
    logic [13:0] ch0_q, ch0_d;
    logic [13:0] ch1_q, ch1_d;
    logic [15:0] sample_l_q, sample_l_d;
    logic [15:0] sample_r_q, sample_r_d;
    logic        conv_q, conv_d;
    logic        sck_q, sck_d;
    logic        valid_q, valid_d;
    logic        in_frame_d;
    logic        sample_edge;

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        slot_d  = slot_q;
        case (state_q)
            StIdle: begin
                sub_d  = 4'd0;
                slot_d = 6'd0;
                if (bus.en) state_d = StFrame;
            end
            StFrame: begin
                sub_d = sub_q + 4'd1;
                if (sub_q == 4'd15) begin
                    // slot wraps 63 -> 0 naturally; en is only looked at here
                    slot_d = slot_q + 6'd1;
                    if (slot_q == 6'd63 && !bus.en) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sample_edge = (state_q == StFrame) && (sub_q == 4'd12);

    always_comb begin
        ch0_d = ch0_q;
        ch1_d = ch1_q;
        if (sample_edge) begin
            if (slot_q >= 6'd3 && slot_q <= 6'd16) ch0_d = {ch0_q[12:0], bus.miso};
            if (slot_q >= 6'd19 && slot_q <= 6'd32) ch1_d = {ch1_q[12:0], bus.miso};
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        in_frame_d = (state_d == StFrame);
        conv_d     = in_frame_d && (slot_d == 6'd0);
        sck_d      = in_frame_d && (slot_d >= 6'd1) && (slot_d <= 6'd34) && sub_d[3];
        valid_d    = in_frame_d && (slot_d == 6'd35) && (sub_d == 4'd0);
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        if (valid_d) begin
            sample_l_d = {{2{ch0_q[13]}}, ch0_q};
            sample_r_d = {{2{ch1_q[13]}}, ch1_q};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            sub_q      <= 4'd0;
            slot_q     <= 6'd0;
            ch0_q      <= 14'd0;
            ch1_q      <= 14'd0;
            sample_l_q <= 16'd0;
            sample_r_q <= 16'd0;
            conv_q     <= 1'b0;
            sck_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            slot_q     <= slot_d;
            ch0_q      <= ch0_d;
            ch1_q      <= ch1_d;
            sample_l_q <= sample_l_d;
            sample_r_q <= sample_r_d;
            conv_q     <= conv_d;
            sck_q      <= sck_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.conv     = conv_q;
    assign bus.sck      = sck_q;
    assign bus.valid    = valid_q;
    assign bus.sample_l = sample_l_q;
    assign bus.sample_r = sample_r_q;

endmodule

// File: tb/tb_adc_rx.sv
// Bench for adc_rx: serial ADC model, frame-time reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_adc_rx;

    logic clk = 1'b0;
    logic reset_n;

    adc_rx_if bus ();

    adc_rx dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] ch0_tbl [8] = '{14'h1FFF, 14'h2000, 14'h1234, 14'h0555,
                                 14'h0ABC, 14'h3FFE, 14'h0000, 14'h0000};
    logic [13:0] ch1_tbl [8] = '{14'h0001, 14'h3FFF, 14'h2ABC, 14'h3000,
                                 14'h1111, 14'h0F0F, 14'h0000, 14'h0000};

    function automatic logic [15:0] sext(input logic [13:0] v);
        return {{2{v[13]}}, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ADC: a new word per conv pulse; after the k-th sck fall it presents the bit for slot k+1.
    int adc_cnt = 0;
    int fall_k  = 0;
    always @(posedge bus.conv or negedge bus.sck) begin
        logic [13:0] w0, w1;
        if (bus.conv) begin
            adc_cnt = adc_cnt + 1;
            fall_k  = 0;
            bus.miso = 1'($urandom_range(0, 1));
        end else begin
            fall_k = fall_k + 1;
            w0 = ch0_tbl[(adc_cnt - 1) % 8];
            w1 = ch1_tbl[(adc_cnt - 1) % 8];
            if (fall_k >= 2 && fall_k <= 15)       bus.miso = w0[15 - fall_k];
            else if (fall_k >= 18 && fall_k <= 31) bus.miso = w1[31 - fall_k];
            else                                   bus.miso = 1'($urandom_range(0, 1));
        end
    end

    // Reference model: position t in a 1024-clk frame, outputs derived arithmetically from t.
    bit          m_run = 1'b0;
    int          m_t   = 0;
    int          m_cnt = 0;
    logic [15:0] m_sl  = 16'd0;
    logic [15:0] m_sr  = 16'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run <= 1'b0;
            m_t   <= 0;
            m_sl  <= 16'd0;
            m_sr  <= 16'd0;
        end else begin
            if (!m_run) begin
                if (bus.en) begin
                    m_run <= 1'b1;
                    m_t   <= 0;
                    m_cnt <= m_cnt + 1;
                end
            end else if (m_t == 1023) begin
                m_t <= 0;
                if (bus.en) m_cnt <= m_cnt + 1;
                else        m_run <= 1'b0;
            end else begin
                m_t <= m_t + 1;
            end
            if (m_run && m_t == 559) begin
                m_sl <= sext(ch0_tbl[(m_cnt - 1) % 8]);
                m_sr <= sext(ch1_tbl[(m_cnt - 1) % 8]);
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("conv", 32'(bus.conv), 32'(m_run && m_t < 16));
            check("sck", 32'(bus.sck),
                  32'(m_run && (m_t / 16) >= 1 && (m_t / 16) <= 34 && (m_t % 16) >= 8));
            check("valid", 32'(bus.valid), 32'(m_run && m_t == 560));
            check("sample_l", 32'(bus.sample_l), 32'(m_sl));
            check("sample_r", 32'(bus.sample_r), 32'(m_sr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cyc, output int conv_hi, output int sck_pulses);
        logic prev_sck;
        bit   seen;
        cyc = 0; conv_hi = 0; sck_pulses = 0; prev_sck = 1'b0; seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            cyc++;
            if (bus.conv) conv_hi++;
            if (bus.sck && !prev_sck) sck_pulses++;
            prev_sck = bus.sck;
            if (bus.valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_conv_rise();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (bus.conv) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("conv_timeout", 32'd0, 32'd1);
    endtask

    int cyc, conv_hi, sck_p, idle_conv, idle_valid;

    initial begin
        reset_n = 1'b1;
        bus.en  = 1'b0;
        #1;
        reset_n = 1'b0;
        bus.en  = 1'b1;
        chk_en  = 1'b1;
        repeat (3) tick();
        check("rst_conv", 32'(bus.conv), 32'd0);
        check("rst_sck", 32'(bus.sck), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_sample_l", 32'(bus.sample_l), 32'h0);
        check("rst_sample_r", 32'(bus.sample_r), 32'h0);

        // Frame 0: start edge is the first clk after release; valid 560 edges later.
        reset_n = 1'b1;
        wait_valid(cyc, conv_hi, sck_p);
        check("f0_latency", 32'(cyc), 32'd561);
        check("f0_conv_len", 32'(conv_hi), 32'd16);
        check("f0_sck_pulses", 32'(sck_p), 32'd34);
        check("f0_sample_l", 32'(bus.sample_l), 32'h1FFF);
        check("f0_sample_r", 32'(bus.sample_r), 32'h0001);

        wait_valid(cyc, conv_hi, sck_p);
        check("f1_period", 32'(cyc), 32'd1024);
        check("f1_sck_pulses", 32'(sck_p), 32'd34);
        check("f1_sample_l", 32'(bus.sample_l), 32'hE000);
        check("f1_sample_r", 32'(bus.sample_r), 32'hFFFF);

        wait_valid(cyc, conv_hi, sck_p);
        check("f2_period", 32'(cyc), 32'd1024);
        check("f2_sample_l", 32'(bus.sample_l), 32'h1234);
        check("f2_sample_r", 32'(bus.sample_r), 32'hEABC);

        // Frame 3: en dropped at slot 10; the frame still completes.
        wait_conv_rise();
        repeat (160) tick();
        bus.en = 1'b0;
        wait_valid(cyc, conv_hi, sck_p);
        check("f3_latency", 32'(cyc), 32'd400);
        check("f3_sample_l", 32'(bus.sample_l), 32'h0555);
        check("f3_sample_r", 32'(bus.sample_r), 32'hF000);
        idle_conv = 0; idle_valid = 0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (bus.conv) idle_conv++;
            if (bus.valid) idle_valid++;
        end
        check("stop_conv_cnt", 32'(idle_conv), 32'd0);
        check("stop_valid_cnt", 32'(idle_valid), 32'd0);
        check("stop_hold_l", 32'(bus.sample_l), 32'h0555);

        // Frame 4 aborted by reset at slot 20, frame 5 restarts cleanly.
        bus.en = 1'b1;
        wait_conv_rise();
        repeat (320) tick();
        reset_n = 1'b0;
        tick();
        check("abort_sample_l", 32'(bus.sample_l), 32'h0);
        check("abort_sample_r", 32'(bus.sample_r), 32'h0);
        check("abort_conv", 32'(bus.conv), 32'd0);
        check("abort_valid", 32'(bus.valid), 32'd0);
        tick();
        reset_n = 1'b1;
        wait_valid(cyc, conv_hi, sck_p);
        check("f5_latency", 32'(cyc), 32'd561);
        check("f5_conv_len", 32'(conv_hi), 32'd16);
        check("f5_sample_l", 32'(bus.sample_l), 32'hFFFE);
        check("f5_sample_r", 32'(bus.sample_r), 32'h0F0F);

        bus.en = 1'b0;
        repeat (600) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
